// File: rtl/baud_autodetect.sv
// Auto-baud controller: measures a 0x55 sync character on rx and derives the
// 16x-oversampling divisor for the UART baud generator.
module baud_autodetect #(
    parameter int DVSR_W       = 11,
    parameter int CNT_W        = 20,
    parameter int DEFAULT_DVSR = 650
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    input  logic              start,
    output logic [DVSR_W-1:0] dvsr,
    output logic              locked,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int Q_W = CNT_W - 6;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_START = 3'd1;
    localparam logic [2:0] MEASURE    = 3'd2;
    localparam logic [2:0] STOP       = 3'd3;
    localparam logic [2:0] SUCCESS    = 3'd4;
    localparam logic [2:0] FAIL       = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic             fall;
    logic             rise;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] t_meas;
    logic [2:0]       fcnt;

    logic [CNT_W:0]   t_round;
    logic [Q_W-1:0]   q;
    logic [31:0]      q_ext;
    logic             q_ok;
    logic [DVSR_W-1:0] dvsr_new;
    logic [CNT_W-1:0] stop_limit;

    // Synchronizer flops reset to the idle line level so release never fakes an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;
    assign rise = ~rx_prev & rx_s;

    // Divide eight bit periods by 128 (8 bits x 16 oversampling) with rounding.
    always_comb begin
        t_round    = {1'b0, t_meas} + (CNT_W + 1)'(64);
        q          = Q_W'(t_round >> 7);
        q_ext      = 32'(q);
        q_ok       = (q_ext >= 32'd2) && (q_ext <= (32'd1 << DVSR_W));
        dvsr_new   = DVSR_W'(q - Q_W'(1));
        stop_limit = t_meas >> 2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            fcnt   <= '0;
            t_meas <= '0;
            dvsr   <= DVSR_W'(DEFAULT_DVSR);
            locked <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        locked <= 1'b0;
                        state  <= WAIT_START;
                    end
                end

                WAIT_START: begin
                    if (fall) begin
                        cnt   <= '0;
                        fcnt  <= 3'd1;
                        state <= MEASURE;
                    end
                end

                // The fifth falling edge closes an eight-bit-period window.
                MEASURE: begin
                    if (fall && (fcnt == 3'd4)) begin
                        t_meas <= cnt;
                        cnt    <= '0;
                        state  <= STOP;
                    end else begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (fall) begin
                            fcnt <= fcnt + 3'd1;
                        end
                        if (cnt == CNT_MAX) begin
                            state <= FAIL;
                        end
                    end
                end

                // The stop bit must rise within a quarter of the measured window.
                STOP: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (rise && (cnt <= stop_limit)) begin
                        if (q_ok) begin
                            dvsr   <= dvsr_new;
                            locked <= 1'b1;
                            state  <= SUCCESS;
                        end else begin
                            state <= FAIL;
                        end
                    end else if (cnt > stop_limit) begin
                        state <= FAIL;
                    end
                end

                SUCCESS: state <= IDLE;
                FAIL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == SUCCESS);
    assign error = (state == FAIL);

endmodule

// File: tb/tb_baud_autodetect.sv
// Scoreboard bench for baud_autodetect: stimulus queues expected done/error
// responses, a negedge monitor pops and compares them.
module tb_baud_autodetect;

    localparam int DVSR_W       = 11;
    localparam int CNT_W        = 14;
    localparam int DEFAULT_DVSR = 650;

    typedef struct packed {
        logic [1:0]        flags;
        logic [DVSR_W-1:0] dvsr;
        logic              locked;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              rx = 1'b1;
    logic              start = 1'b0;
    logic [DVSR_W-1:0] dvsr;
    logic              locked;
    logic              busy;
    logic              done;
    logic              error;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    baud_autodetect #(
        .DVSR_W      (DVSR_W),
        .CNT_W       (CNT_W),
        .DEFAULT_DVSR(DEFAULT_DVSR)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rx     (rx),
        .start  (start),
        .dvsr   (dvsr),
        .locked (locked),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (done || error) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_response: done=%0b error=%0b with nothing expected", done, error);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("resp_kind", {30'b0, done, error}, {30'b0, mon_e.flags});
                check_output("resp_dvsr", 32'(dvsr), 32'(mon_e.dvsr));
                check_output("resp_locked", 32'(locked), 32'(mon_e.locked));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [1:0] flags, input logic [31:0] d, input logic l);
        exp_t e;
        e.flags  = flags;
        e.dvsr   = d[DVSR_W-1:0];
        e.locked = l;
        exp_q.push_back(e);
    endtask

    task automatic arm();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_output("armed_busy", 32'(busy), 32'd1);
        tick(3);
    endtask

    // Sends start, 0x55 LSB first, then the stop bit; optionally pulses start at one bit.
    task automatic apply_stimulus(input int len, input logic stop_bit, input int pulse_bit);
        logic [7:0] data;
        logic [9:0] fb;
        data = 8'h55;
        fb   = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = fb[b];
            if (b == pulse_bit) begin
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(len - 1);
            end else begin
                tick(len);
            end
        end
        if (!stop_bit) begin
            tick(len);
        end
        rx = 1'b1;
        tick(4);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got %0d pending responses, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_dvsr"}, 32'(dvsr), 32'd650);
        check_output({tag, "_locked"}, 32'(locked), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        tick(4);
        reset_n = 1'b1;
        tick(2);
        check_reset_values("reset");

        // 1790 cycles/bit: T = 14319, q = 112
        arm();
        expect_resp(2'b10, 32'd111, 1'b1);
        apply_stimulus(1790, 1'b1, -1);
        wait_drain(2000, "slow_frame");
        check_output("slow_busy", 32'(busy), 32'd0);
        check_output("slow_dvsr", 32'(dvsr), 32'd111);

        // 868 cycles/bit: T = 6943, q = 54; stray start mid-frame must be ignored
        arm();
        expect_resp(2'b10, 32'd53, 1'b1);
        apply_stimulus(868, 1'b1, 3);
        wait_drain(2000, "fast_frame");
        check_output("fast_dvsr", 32'(dvsr), 32'd53);
        check_output("fast_locked", 32'(locked), 32'd1);

        // One falling edge then a stuck-low line saturates the counter
        arm();
        expect_resp(2'b01, 32'd53, 1'b0);
        rx = 1'b0;
        wait_drain(20000, "timeout");
        rx = 1'b1;
        tick(3);
        check_output("timeout_dvsr", 32'(dvsr), 32'd53);
        check_output("timeout_locked", 32'(locked), 32'd0);
        check_output("timeout_busy", 32'(busy), 32'd0);

        // 8 cycles/bit: q = 0 -> too fast
        arm();
        expect_resp(2'b01, 32'd53, 1'b0);
        apply_stimulus(8, 1'b1, -1);
        wait_drain(2000, "too_fast_8");

        // 23 cycles/bit: q = 1, just below the lower bound
        arm();
        expect_resp(2'b01, 32'd53, 1'b0);
        apply_stimulus(23, 1'b1, -1);
        wait_drain(2000, "too_fast_23");

        // 25 cycles/bit: q = 2, smallest accepted divisor
        arm();
        expect_resp(2'b10, 32'd1, 1'b1);
        apply_stimulus(25, 1'b1, -1);
        wait_drain(2000, "edge_25");
        check_output("edge_dvsr", 32'(dvsr), 32'd1);

        // Stop bit held low -> framing failure
        arm();
        expect_resp(2'b01, 32'd1, 1'b0);
        apply_stimulus(868, 1'b0, -1);
        wait_drain(4000, "framing");
        check_output("framing_dvsr", 32'(dvsr), 32'd1);
        check_output("framing_locked", 32'(locked), 32'd0);

        // Reset after the third falling edge, then a clean detection
        arm();
        rx = 1'b0; tick(868);
        rx = 1'b1; tick(868);
        rx = 1'b0; tick(868);
        rx = 1'b1; tick(868);
        rx = 1'b0; tick(20);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick(3);
        rx = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        arm();
        expect_resp(2'b10, 32'd53, 1'b1);
        apply_stimulus(868, 1'b1, -1);
        wait_drain(2000, "after_reset_frame");
        check_output("after_reset_dvsr", 32'(dvsr), 32'd53);
        check_output("after_reset_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
